// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_FIX  = 3'd2,
    S_DONE = 3'd3,
    S_ZERO = 3'd4
  } div_state_t;

  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] v
  );
    return v[WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration on unsigned magnitudes.
module div_step
  import div_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_dvs,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_quo
);

  logic [W:0] w_sh;
  logic [W:0] w_trial;
  logic       w_neg;

  always_comb begin
    w_sh    = {i_rem, i_quo[W-1]};
    w_trial = w_sh - {1'b0, i_dvs};
    w_neg   = w_trial[W];
    o_rem   = w_neg ? w_sh[W-1:0] : w_trial[W-1:0];
    o_quo   = {i_quo[W-2:0], ~w_neg};
  end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider: quotient to LO, remainder to HI,
// DivCtrl/DivOut/divZero handshake with the control unit.
module div_unit
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             DivOut,
  output logic             divZero
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_t       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sq;
  logic             r_sr;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_done;
  logic             r_zero;

  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quo;

  div_step #(.W(WIDTH)) u_step (
    .i_rem(r_rem),
    .i_quo(r_quo),
    .i_dvs(r_dvs),
    .o_rem(w_rem),
    .o_quo(w_quo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_sq    <= 1'b0;
      r_sr    <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_done  <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (DivCtrl) begin
            if (rt_data == '0) begin
              r_zero  <= 1'b1;
              r_state <= S_ZERO;
            end else begin
              r_quo   <= mag(rs_data);
              r_dvs   <= mag(rt_data);
              r_sq    <= rs_data[WIDTH-1] ^ rt_data[WIDTH-1];
              r_sr    <= rs_data[WIDTH-1];
              r_rem   <= '0;
              r_cnt   <= '0;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!DivCtrl) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem;
            r_quo <= w_quo;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST)
              r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!DivCtrl) begin
            r_state <= S_IDLE;
          end else begin
            // negation wraps, so MIN / -1 lands on MIN with no flag
            r_lo    <= r_sq ? -r_quo : r_quo;
            r_hi    <= r_sr ? -r_rem : r_rem;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!DivCtrl) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_ZERO: begin
          if (!DivCtrl) begin
            r_zero  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lo_out  = r_lo;
  assign hi_out  = r_hi;
  assign DivOut  = r_done;
  assign divZero = r_zero;

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against
// a plain-arithmetic signed division model.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        DivCtrl;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] lo_out;
  logic [31:0] hi_out;
  logic        DivOut;
  logic        divZero;

  int n_chk;
  int n_err;

  logic [31:0] exp_lo;
  logic [31:0] exp_hi;

  div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .DivCtrl(DivCtrl),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .lo_out (lo_out),
    .hi_out (hi_out),
    .DivOut (DivOut),
    .divZero(divZero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return {32'h8000_0000, 32'h0};
    return {32'(sa / sb), 32'(sa % sb)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a divide, checks latency and result, leaves DivCtrl high.
  task automatic start_div(
    input logic [31:0] a,
    input logic [31:0] b,
    input string       tag
  );
    logic [63:0] r;
    int          lat;
    r = ref_div(a, b);
    DivCtrl = 1'b1;
    rs_data = a;
    rt_data = b;
    tick();
    rs_data = $urandom;
    rt_data = $urandom;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (DivOut) begin
        lat = i;
        break;
      end
    end
    chk({tag, " lat"}, 32'(lat), 32'd33);
    chk({tag, " lo"}, lo_out, r[63:32]);
    chk({tag, " hi"}, hi_out, r[31:0]);
    chk({tag, " dz"}, {31'd0, divZero}, 32'd0);
    exp_lo = r[63:32];
    exp_hi = r[31:0];
  endtask

  task automatic release_ctrl();
    DivCtrl = 1'b0;
    tick();
    chk("drop DivOut", {31'd0, DivOut}, 32'd0);
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    reset   = 1'b1;
    DivCtrl = 1'b0;
    rs_data = '0;
    rt_data = '0;
    exp_lo  = '0;
    exp_hi  = '0;
    #12;
    chk("rst lo", lo_out, 32'd0);
    chk("rst hi", hi_out, 32'd0);
    chk("rst flags", {30'd0, DivOut, divZero}, 32'd0);
    reset = 1'b0;
    tick();

    start_div(32'd100, 32'd7, "100/7");
    chk("100/7 lo const", lo_out, 32'd14);
    chk("100/7 hi const", hi_out, 32'd2);
    release_ctrl();
    start_div(32'hFFFF_FFF9, 32'd2, "-7/2");
    chk("-7/2 lo const", lo_out, 32'hFFFF_FFFD);
    chk("-7/2 hi const", hi_out, 32'hFFFF_FFFF);
    release_ctrl();
    start_div(32'd7, 32'hFFFF_FFFE, "7/-2");
    chk("7/-2 hi const", hi_out, 32'd1);
    release_ctrl();

    // divide by zero keeps the prior result
    DivCtrl = 1'b1;
    rs_data = 32'd5;
    rt_data = 32'd0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("dz flag", {31'd0, divZero}, 32'd1);
      chk("dz DivOut", {31'd0, DivOut}, 32'd0);
      chk("dz lo", lo_out, exp_lo);
      chk("dz hi", hi_out, exp_hi);
      tick();
    end
    DivCtrl = 1'b0;
    tick();
    chk("dz clear", {31'd0, divZero}, 32'd0);

    start_div(32'h8000_0000, 32'hFFFF_FFFF, "min/-1");
    chk("min/-1 lo const", lo_out, 32'h8000_0000);
    release_ctrl();
    start_div(32'h8000_0000, 32'd1, "min/1");
    release_ctrl();
    start_div(32'h8000_0000, 32'h8000_0000, "min/min");
    release_ctrl();

    // abort after 10 cycles
    DivCtrl = 1'b1;
    rs_data = 32'd1000;
    rt_data = 32'd3;
    tick();
    for (int i = 0; i < 10; i++) tick();
    DivCtrl = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (DivOut) seen++;
      end
      chk("abort DivOut", 32'(seen), 32'd0);
    end
    chk("abort lo", lo_out, exp_lo);
    chk("abort hi", hi_out, exp_hi);

    // reset mid-run clears outputs without a clock edge
    DivCtrl = 1'b1;
    rs_data = 32'd1000;
    rt_data = 32'd3;
    tick();
    for (int i = 0; i < 19; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mid rst lo", lo_out, 32'd0);
    chk("mid rst hi", hi_out, 32'd0);
    chk("mid rst flags", {30'd0, DivOut, divZero}, 32'd0);
    DivCtrl = 1'b0;
    #1;
    reset = 1'b0;
    tick();

    // hold past DONE: no restart
    start_div(32'd50, 32'd6, "50/6");
    rs_data = 32'd1;
    rt_data = 32'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold DivOut", {31'd0, DivOut}, 32'd1);
      chk("hold lo", lo_out, exp_lo);
      chk("hold dz", {31'd0, divZero}, 32'd0);
    end
    DivCtrl = 1'b0;
    tick();
    start_div(32'd9, 32'd3, "9/3");
    chk("9/3 lo const", lo_out, 32'd3);
    release_ctrl();

    for (int n = 0; n < 24; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if (n % 3 == 1) b = b >> $urandom_range(31, 16);
      if (n % 4 == 2) b = -b;
      if (b == 32'd0) b = 32'd1;
      start_div(a, b, "rand");
      release_ctrl();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
